// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the EX/MEM pipeline register and data_mem_ctrl.
// master = pipeline side, slave = memory controller side.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  logic              busy;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory with registered read path (READ_LAT 1 or 2).
// Optional alignment/range faults are enabled by defining DM_FAULT_EN.
module data_mem_ctrl #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int READ_LAT    = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef logic [DEPTH_BYTES-1:0][7:0] mem_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  function automatic mem_t init_image();
    mem_t img;
    for (int a = 0; a < DEPTH_BYTES; a++) img[a] = 8'(((a >> 3) & 15) * 17);
    return img;
  endfunction

  // A 32-bit datapath has no doubleword; fold size 3 onto a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] sz);
    return (DATA_W == 32 && sz == 2'd3) ? 2'd2 : sz;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] sz,
                                         input logic sgn);
    logic [63:0] res;
    case (sz)
      2'd0:    res = {{56{sgn & raw[7]}},  raw[7:0]};
      2'd1:    res = {{48{sgn & raw[15]}}, raw[15:0]};
      2'd2:    res = {{32{sgn & raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  mem_t              r_mem = init_image();
  state_t            r_state, w_state_nxt;
  logic              w_ready;
  logic              w_accept;
  logic [1:0]        w_size;
  logic [3:0]        w_nbytes;
  logic [AW-1:0]     w_idx [8];
  logic [63:0]       w_wdata_lj;
  logic [63:0]       w_raw;
  logic [63:0]       w_load;
  logic              w_fault;
  logic [DATA_W-1:0] w_rdata_new;
  logic [DATA_W-1:0] r_rdata_p0;
  logic              r_fault_p0;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_fault;

  assign w_size     = eff_size(bus.req_size);
  assign w_nbytes   = 4'd1 << w_size;
  assign w_ready    = (r_state == IDLE) || (r_state == RESP);
  assign w_accept   = bus.req_valid && w_ready;
  // Left-justify store data so byte k of the access is always bits [63-8k -: 8].
  assign w_wdata_lj = 64'(bus.req_wdata) << {(4'd8 - w_nbytes), 3'b000};

  always_comb begin
    for (int k = 0; k < 8; k++) w_idx[k] = bus.req_addr[AW-1:0] + AW'(k);
  end

`ifdef DM_FAULT_EN
  logic w_misalign;
  logic w_range;
  assign w_misalign = (bus.req_addr[2:0] & 3'(w_nbytes - 4'd1)) != 3'd0;
  assign w_range    = (bus.req_addr >> AW) != '0;
  assign w_fault    = w_misalign | w_range;
`else
  logic w_unused_upper_addr;
  assign w_unused_upper_addr = ^(bus.req_addr >> AW);
  assign w_fault             = 1'b0;
`endif

  // Big-endian gather: lowest address lands in the most significant byte.
  always_comb begin
    w_raw = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < w_nbytes) w_raw = {w_raw[55:0], r_mem[w_idx[k]]};
    end
  end

  assign w_load      = extend(w_raw, w_size, bus.req_signed);
  assign w_rdata_new = (bus.req_write || w_fault) ? '0 : DATA_W'(w_load);

  always_ff @(posedge clock) begin
    if (w_accept && bus.req_write && !w_fault) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < w_nbytes) r_mem[w_idx[k]] <= w_wdata_lj[63-8*k -: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (READ_LAT == 2) ? WAIT : RESP;
      WAIT:    w_state_nxt = RESP;
      RESP:    w_state_nxt = w_accept ? ((READ_LAT == 2) ? WAIT : RESP) : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0: load result captured at the accept edge
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_rdata_p0 <= w_rdata_new;
      r_fault_p0 <= w_fault;
    end
  end

  // Response stage: outputs only change when a new response is presented
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
    end else if (READ_LAT == 2) begin
      if (r_state == WAIT) begin
        r_rsp_rdata <= r_rdata_p0;
        r_rsp_fault <= r_fault_p0;
      end
    end else if (w_accept) begin
      r_rsp_rdata <= w_rdata_new;
      r_rsp_fault <= w_fault;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.busy      = (r_state != IDLE);
endmodule
